// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer between fetch and the micro-op decode stage.
// Circular FIFO of {instruction, PC} pairs with a registered-count-only ready.
module instr_prefetch_buffer #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'hE1A00000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                InstrF,
  input  logic [31:0]                PCF,
  input  logic                       InstrValidF,
  output logic                       BufReadyF,
  input  logic                       uOpStallD,
  input  logic                       StallD,
  input  logic                       FlushD,
  output logic [31:0]                defaultInstrD,
  output logic [31:0]                PCD,
  output logic                       InstrValidD,
  output logic [$clog2(DEPTH+1)-1:0] CountD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          empty;

  // Handshakes: a transfer happens on an edge where the producer's valid and
  // the consumer's ready are both high. Fetch side: InstrValidF / BufReadyF.
  // Decode side: InstrValidD / (~uOpStallD & ~StallD). FlushD cancels both.
  assign empty     = (count_q == '0);
  assign BufReadyF = (count_q != CW'(DEPTH));
  assign push      = InstrValidF & BufReadyF & ~FlushD;
  assign pop       = InstrValidD & ~uOpStallD & ~StallD & ~FlushD;

  // Pointers and count only; the storage array is deliberately left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (FlushD) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= InstrF;
      pc_mem[wr_ptr_q]    <= PCF;
    end
  end

  // Head is read only from registered state, so a push becomes visible one
  // cycle after its edge and stalls cannot disturb it.
  always_comb begin
    defaultInstrD = NOP;
    PCD           = 32'h0;
    InstrValidD   = 1'b0;
    if (!empty) begin
      defaultInstrD = instr_mem[rd_ptr_q];
      PCD           = pc_mem[rd_ptr_q];
      InstrValidD   = 1'b1;
    end
  end

  assign CountD = count_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=4): reset, latency, stall
// hold, overflow drop, streaming wrap, flush and asynchronous reset.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] NOP_W = 32'hE1A00000;

  logic        clk;
  logic        reset;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        InstrValidF;
  logic        BufReadyF;
  logic        uOpStallD;
  logic        StallD;
  logic        FlushD;
  logic [31:0] defaultInstrD;
  logic [31:0] PCD;
  logic        InstrValidD;
  logic [2:0]  CountD;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  instr_prefetch_buffer #(.DEPTH(4), .NOP(32'hE1A00000)) dut (
    .clk           (clk),
    .reset         (reset),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .InstrValidF   (InstrValidF),
    .BufReadyF     (BufReadyF),
    .uOpStallD     (uOpStallD),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .defaultInstrD (defaultInstrD),
    .PCD           (PCD),
    .InstrValidD   (InstrValidD),
    .CountD        (CountD)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    InstrValidF = v;
    InstrF      = instr;
    PCF         = pc;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic valid, input logic [2:0] cnt);
    check_eq({tag, "_instr"}, {32'h0, defaultInstrD}, {32'h0, instr});
    check_eq({tag, "_pc"},    {32'h0, PCD},           {32'h0, pc});
    check_eq({tag, "_valid"}, {63'h0, InstrValidD},   {63'h0, valid});
    check_eq({tag, "_count"}, {61'h0, CountD},        {61'h0, cnt});
  endtask

  initial begin
    logic [63:0] head;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    uOpStallD = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    drive_fetch(1'b0, 32'h0, 32'h0);
    #1;
    check_head("reset", NOP_W, 32'h0, 1'b0, 3'd0);
    check_eq("reset_ready", {63'h0, BufReadyF}, 64'd1);
    tick();
    reset = 1'b0;

    // single push: no bypass, visible next cycle
    drive_fetch(1'b1, 32'hE0810002, 32'h100);
    #1;
    check_eq("nobypass_valid", {63'h0, InstrValidD}, 64'd0);
    tick();
    drive_fetch(1'b0, 32'h0, 32'h0);
    check_head("single", 32'hE0810002, 32'h100, 1'b1, 3'd1);
    tick();
    check_head("single_pop", NOP_W, 32'h0, 1'b0, 3'd0);

    // fill under uOpStallD, overflow drop, ordered drain
    uOpStallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_fetch(1'b1, 32'hA0000000 + i, 32'h200 + 4 * i);
      tick();
      check_head($sformatf("fill%0d", i), 32'hA0000000, 32'h200, 1'b1, 3'(i + 1));
    end
    check_eq("full_ready", {63'h0, BufReadyF}, 64'd0);
    drive_fetch(1'b1, 32'hDEADBEEF, 32'hBAD);
    tick();
    check_head("overflow", 32'hA0000000, 32'h200, 1'b1, 3'd4);
    drive_fetch(1'b0, 32'h0, 32'h0);
    uOpStallD = 1'b0;
    #1;
    check_eq("ready_no_pop_path", {63'h0, BufReadyF}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), 32'hA0000000 + i, 32'h200 + 4 * i, 1'b1, 3'(4 - i));
      tick();
    end
    check_head("drained", NOP_W, 32'h0, 1'b0, 3'd0);

    // steady stream at occupancy 2 with scoreboard
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_fetch(1'b1, 32'hE2800000 + i, 32'h300 + 4 * i);
      exp_q.push_back({32'hE2800000 + i, 32'h300 + 4 * i});
      tick();
    end
    StallD = 1'b0;
    for (int i = 2; i < 12; i++) begin
      drive_fetch(1'b1, 32'hE2800000 + i, 32'h300 + 4 * i);
      head = exp_q[0];
      check_head($sformatf("stream%0d", i), head[63:32], head[31:0], 1'b1, 3'd2);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back({32'hE2800000 + i, 32'h300 + 4 * i});
    end
    drive_fetch(1'b0, 32'h0, 32'h0);
    while (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check_head("stream_tail", head[63:32], head[31:0], 1'b1, 3'(exp_q.size() + 1));
      tick();
    end
    check_head("stream_end", NOP_W, 32'h0, 1'b0, 3'd0);

    // flush at count 3 with concurrent push
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_fetch(1'b1, 32'hB0000000 + i, 32'h400 + 4 * i);
      tick();
    end
    check_eq("preflush_count", {61'h0, CountD}, 64'd3);
    StallD = 1'b0;
    FlushD = 1'b1;
    drive_fetch(1'b1, 32'hC0000000, 32'h500);
    tick();
    FlushD = 1'b0;
    drive_fetch(1'b0, 32'h0, 32'h0);
    check_head("flush", NOP_W, 32'h0, 1'b0, 3'd0);
    check_eq("flush_ready", {63'h0, BufReadyF}, 64'd1);

    // LDM held under uOpStallD for 4 cycles
    drive_fetch(1'b1, 32'hE8BD000F, 32'h600);
    tick();
    uOpStallD = 1'b1;
    drive_fetch(1'b1, 32'hE3A01001, 32'h604);
    tick();
    drive_fetch(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("ldm_hold%0d", i), 32'hE8BD000F, 32'h600, 1'b1, 3'd2);
      tick();
    end
    check_head("ldm_hold3", 32'hE8BD000F, 32'h600, 1'b1, 3'd2);
    uOpStallD = 1'b0;
    tick();
    check_head("ldm_popped", 32'hE3A01001, 32'h604, 1'b1, 3'd1);
    tick();
    check_head("ldm_follow_pop", NOP_W, 32'h0, 1'b0, 3'd0);

    // asynchronous reset mid-expansion at count 2
    uOpStallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_fetch(1'b1, 32'hF0000000 + i, 32'h700 + 4 * i);
      tick();
    end
    drive_fetch(1'b0, 32'h0, 32'h0);
    check_eq("prereset_count", {61'h0, CountD}, 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_head("async_reset", NOP_W, 32'h0, 1'b0, 3'd0);
    check_eq("async_reset_ready", {63'h0, BufReadyF}, 64'd1);
    #1;
    reset = 1'b0;
    tick();
    drive_fetch(1'b1, 32'h11111111, 32'h800);
    tick();
    drive_fetch(1'b0, 32'h0, 32'h0);
    check_head("post_reset", 32'h11111111, 32'h800, 1'b1, 3'd1);
    uOpStallD = 1'b0;
    tick();
    check_head("post_reset_pop", NOP_W, 32'h0, 1'b0, 3'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffer entries; power of two, minimum 2.
REQ-002 SHALL have parameter NOP, default 32'hE1A00000: encoding (MOV R0,R0) driven on defaultInstrD when the buffer is empty.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port InstrF  input  32  fetched instruction word.
REQ-006 SHALL have port PCF  input  32  address of InstrF.
REQ-007 SHALL have port InstrValidF  input  1  InstrF/PCF hold a valid fetch this cycle.
REQ-008 SHALL have port BufReadyF  output  1  buffer accepts a push this cycle.
REQ-009 SHALL have port uOpStallD  input  1  micro-op sequencer is expanding the head instruction; hold it.
REQ-010 SHALL have port StallD  input  1  decode hazard stall; hold head.
REQ-011 SHALL have port FlushD  input  1  branch/exception flush; discard all entries.
REQ-012 SHALL have port defaultInstrD  output  32  head instruction presented to the micro-op FSM.
REQ-013 SHALL have port PCD  output  32  address of the head instruction.
REQ-014 SHALL have port InstrValidD  output  1  head entry is valid.
REQ-015 SHALL have port CountD  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-016 SHALL store DEPTH entries of {InstrF, PCF} in a circular FIFO with write pointer, read pointer and occupancy count.
REQ-017 SHALL push (store at write pointer, advance it) when InstrValidF & BufReadyF & ~FlushD.
REQ-018 SHALL pop (advance read pointer) when InstrValidD & ~uOpStallD & ~StallD & ~FlushD.
REQ-019 SHALL drive BufReadyF = (CountD != DEPTH), decoded from registered count only; a same-cycle pop SHALL NOT raise BufReadyF.
REQ-020 SHALL drive defaultInstrD/PCD combinationally from the entry at the read pointer when CountD != 0; otherwise NOP and 32'h0, with InstrValidD = 0.
REQ-021 SHALL give a pushed instruction a minimum latency of one cycle: visible on defaultInstrD the cycle after the push edge; no fetch-to-decode bypass.
REQ-022 SHALL, on simultaneous push and pop, keep CountD unchanged and advance both pointers.
REQ-023 SHALL wrap both pointers modulo DEPTH.
REQ-024 SHALL hold defaultInstrD, PCD and the read pointer bit-stable for every cycle uOpStallD or StallD is high, including multi-cycle LDM/RSR/MAC expansions.
REQ-025 SHALL continue accepting pushes while uOpStallD or StallD is high, until full.
REQ-026 SHALL, when FlushD is high at an edge, set both pointers and CountD to 0 and ignore any same-cycle push or pop; FlushD has priority over all stalls.
REQ-027 SHALL never overflow: a push attempt at CountD == DEPTH is dropped and the upstream fetch must hold InstrF/PCF.
REQ-028 SHALL never underflow: no pop occurs when CountD == 0.
REQ-029 SHALL keep CountD equal to (write pointer - read pointer) mod DEPTH, disambiguated by the full state.
REQ-030 SHALL contain no combinational path from uOpStallD, StallD or FlushD to BufReadyF.

Reset
REQ-031 SHALL, while reset is high, asynchronously force both pointers and CountD to 0, so that InstrValidD = 0, defaultInstrD = NOP, PCD = 0 and BufReadyF = 1.
REQ-032 SHALL, on reset asserted mid-expansion (uOpStallD high), discard all entries; the first instruction pushed after reset is the first one presented.
REQ-033 SHALL not reset storage array contents; only pointers and count.

Verification
REQ-034 Reset, then push E0810002@PC 0x100 -> next cycle defaultInstrD = E0810002, PCD = 0x100, InstrValidD = 1, CountD = 1.
REQ-035 Push 4 words with uOpStallD high throughout -> CountD = 4, BufReadyF = 0, 5th push dropped; head unchanged for all cycles; release stall -> pops in order, one per cycle.
REQ-036 Steady stream with one push and one pop per cycle for 10 cycles -> CountD constant, pointers wrap past DEPTH-1, PC order preserved.
REQ-037 CountD = 3, FlushD high coinciding with a push and no stall -> next cycle CountD = 0, InstrValidD = 0, defaultInstrD = E1A00000.
REQ-038 LDM E8BD000F at head with uOpStallD high for 4 cycles -> defaultInstrD = E8BD000F every cycle, popped only on the cycle uOpStallD falls.
REQ-039 Assert reset asynchronously between edges with CountD = 2 -> outputs reach reset values before the next clk edge.
